// File: rtl/ddr_frame_prefetch.sv
// Streams one frame of 16-bit words from DDR into a first-word-fall-through
// pixel FIFO, keeping at most one read outstanding.
module ddr_frame_prefetch #(
  parameter int unsigned FRAME_WORDS  = 307200,
  parameter logic [23:0] BASE_ADDRESS = 24'h000000,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk133_p,
  input  logic        rst,
  input  logic        frameStart,
  output logic        read,
  output logic [23:0] readAddress,
  input  logic        readAcknowledge,
  input  logic [15:0] readData,
  input  logic        pixelPop,
  output logic [15:0] pixelData,
  output logic        pixelValid,
  output logic        underflow
);

  // state | meaning
  // IDLE  | after reset, waiting for the first frameStart
  // FETCH | issue the next read once the FIFO has room for its word
  // WAIT  | read outstanding, waiting for readAcknowledge
  // DRAIN | frameStart arrived mid-read; finish it, discard the word, restart
  // DONE  | whole frame requested; the FIFO keeps draining

  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int WORDS_W = $clog2(FRAME_WORDS + 1);

  localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [WORDS_W-1:0] LAST_C  = WORDS_W'(FRAME_WORDS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAIN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [WORDS_W-1:0] words_issued;
  logic [15:0]        mem [FIFO_DEPTH];

  logic push;
  logic pop;
  logic flush;

  // Restart (frameStart, or the discarded acknowledge in DRAIN) beats any push or pop.
  assign flush = frameStart || ((state == DRAIN) && readAcknowledge);
  assign push  = !rst && !flush && (state == WAIT) && readAcknowledge;
  assign pop   = !flush && pixelPop && (count != '0);

  assign pixelValid = (count != '0);
  assign pixelData  = mem[rd_ptr];

  always_ff @(posedge clk133_p) begin
    if (push) mem[wr_ptr] <= readData;
  end

  always_ff @(posedge clk133_p) begin
    if (rst) begin
      state        <= IDLE;
      read         <= 1'b0;
      readAddress  <= BASE_ADDRESS;
      words_issued <= '0;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      underflow    <= 1'b0;
    end else begin
      if (flush) begin
        count     <= '0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        underflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
        if (pixelPop && (count == '0)) underflow <= 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (frameStart) begin
            readAddress  <= BASE_ADDRESS;
            words_issued <= '0;
            state        <= FETCH;
          end
        end
        FETCH: begin
          if (frameStart) begin
            readAddress  <= BASE_ADDRESS;
            words_issued <= '0;
          end else if (count < DEPTH_C) begin
            read  <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (readAcknowledge) begin
            read <= 1'b0;
            if (frameStart) begin
              readAddress  <= BASE_ADDRESS;
              words_issued <= '0;
              state        <= FETCH;
            end else begin
              readAddress  <= readAddress + 24'd1;
              words_issued <= words_issued + 1'b1;
              state        <= (words_issued == LAST_C) ? DONE : FETCH;
            end
          end else if (frameStart) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (readAcknowledge) begin
            read         <= 1'b0;
            readAddress  <= BASE_ADDRESS;
            words_issued <= '0;
            state        <= FETCH;
          end
        end
        default: begin
          read  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_frame_prefetch.sv
// Randomized bench for ddr_frame_prefetch against a transaction-level model:
// a word queue, an expected next address and a frame word budget.
module tb_ddr_frame_prefetch;

  localparam int          FRAME_WORDS = 20;
  localparam logic [23:0] BASE        = 24'hFFFFFE;
  localparam int          DEPTH       = 16;

  logic        clk133_p = 1'b0;
  logic        rst = 1'b1;
  logic        frameStart = 1'b0;
  logic        readAcknowledge = 1'b0;
  logic [15:0] readData = '0;
  logic        pixelPop = 1'b0;
  logic        read;
  logic [23:0] readAddress;
  logic [15:0] pixelData;
  logic        pixelValid;
  logic        underflow;

  ddr_frame_prefetch #(
    .FRAME_WORDS (FRAME_WORDS),
    .BASE_ADDRESS(BASE),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk133_p       (clk133_p),
    .rst            (rst),
    .frameStart     (frameStart),
    .read           (read),
    .readAddress    (readAddress),
    .readAcknowledge(readAcknowledge),
    .readData       (readData),
    .pixelPop       (pixelPop),
    .pixelData      (pixelData),
    .pixelValid     (pixelValid),
    .underflow      (underflow)
  );

  always #5 clk133_p = ~clk133_p;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // reference model state
  logic [15:0] q[$];
  logic [23:0] addr_exp  = BASE;
  int          issued    = 0;
  bit          uf_exp    = 1'b0;
  bit          active    = 1'b0;
  bit          drain     = 1'b0;
  bit          prev_read = 1'b0;
  bit          prev_ack  = 1'b0;
  bit          prev_rst  = 1'b1;
  logic [23:0] held_addr = '0;
  int          starve    = 0;
  int          ack_wait  = 0;
  int          ack_max   = 3;

  function automatic bit held();
    return prev_read && !prev_ack && !prev_rst;
  endfunction

  // Called at a falling edge: check outputs, advance the model over the next
  // rising edge, drive the inputs for it, then move to the next falling edge.
  task automatic cycle(input bit r, input bit fs, input bit pop, input bit ack_in,
                       input logic [15:0] data);
    bit ack;
    check_eq("pixelValid", pixelValid, q.size() != 0);
    if (q.size() != 0) check_eq("pixelData", pixelData, q[0]);
    check_eq("underflow", underflow, uf_exp);
    if (prev_rst) begin
      check_eq("rst_read", read, 0);
      check_eq("rst_addr", readAddress, BASE);
    end else if (prev_ack) begin
      check_eq("read_drop", read, 0);
      check_eq("addr_after_ack", readAddress, addr_exp);
    end else if (prev_read) begin
      check_eq("read_hold", read, 1);
      check_eq("addr_hold", readAddress, held_addr);
    end
    if (read && !held()) begin
      check_eq("req_addr", readAddress, addr_exp);
      check_eq("req_room", q.size() < DEPTH, 1);
      check_eq("req_budget", issued < FRAME_WORDS, 1);
      check_eq("req_active", active, 1);
    end
    if (!read && active && !drain && issued < FRAME_WORDS && q.size() < DEPTH) begin
      starve++;
      check_eq("req_latency", starve <= 2, 1);
    end else begin
      starve = 0;
    end

    ack = ack_in && read;
    if (r) begin
      q.delete();
      addr_exp = BASE; issued = 0; uf_exp = 0; active = 0; drain = 0;
    end else begin
      if (!fs && pop) begin
        if (q.size() != 0) void'(q.pop_front());
        else uf_exp = 1;
      end
      if (ack && !drain && !fs) begin
        q.push_back(data);
        addr_exp = addr_exp + 24'd1;
        issued++;
      end
      if (fs) begin
        q.delete();
        uf_exp = 0;
        active = 1;
        if (read && !ack) drain = 1;
        else begin addr_exp = BASE; issued = 0; drain = 0; end
      end else if (ack && drain) begin
        q.delete();
        uf_exp = 0; addr_exp = BASE; issued = 0; drain = 0;
      end
    end
    prev_read = read;
    prev_ack  = ack;
    prev_rst  = r;
    held_addr = readAddress;

    rst = r; frameStart = fs; pixelPop = pop; readAcknowledge = ack_in; readData = data;
    @(negedge clk133_p);
  endtask

  task automatic idle_until_read(input int limit);
    int k = 0;
    while (!read && k < limit) begin
      cycle(0, 0, 0, 0, 16'h0);
      k++;
    end
    check_eq("read_timeout", read, 1);
  endtask

  task automatic rand_run(input int n, input int pop_pct, input int fs_permille);
    int since_fs = 10;
    for (int i = 0; i < n; i++) begin
      bit a, f, p;
      if (read && !held()) ack_wait = int'($urandom_range(ack_max));
      a = read && (ack_wait == 0);
      if (read && ack_wait > 0) ack_wait--;
      f = (since_fs > 6) && ($urandom_range(999) < fs_permille);
      since_fs = f ? 0 : since_fs + 1;
      p = ($urandom_range(99) < pop_pct);
      cycle(0, f, p, a, 16'($urandom));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk133_p);
    cycle(1, 1, 0, 1, 16'hDEAD);          // rst overrides frameStart and acknowledge
    cycle(0, 0, 0, 0, 16'h0);
    cycle(0, 0, 0, 0, 16'h0);             // still idle: no request
    cycle(0, 1, 0, 0, 16'h0);
    idle_until_read(3);
    repeat (5) cycle(0, 0, 0, 0, 16'h0);
    cycle(0, 0, 0, 1, 16'h0123);
    check_eq("first_word", pixelData, 16'h0123);
    check_eq("first_valid", pixelValid, 1);
    check_eq("first_addr", readAddress, 24'hFFFFFF);

    // fill without popping, then a single pop must trigger a new request
    ack_max = 1;
    rand_run(80, 0, 0);
    check_eq("fill_valid", pixelValid, 1);
    check_eq("fill_stopped", read, 0);
    cycle(0, 0, 1, 0, 16'h0);
    idle_until_read(2);

    // finish the frame with pops, then DONE stays quiet
    ack_max = 3;
    rand_run(200, 70, 0);
    check_eq("done_idle", read, 0);
    rand_run(20, 50, 0);

    // restart from DONE goes back to BASE
    cycle(0, 1, 0, 0, 16'h0);
    idle_until_read(3);
    check_eq("restart_addr", readAddress, BASE);

    // frameStart while a read is outstanding: word discarded, then restart
    cycle(0, 0, 0, 0, 16'h0);
    cycle(0, 1, 0, 0, 16'h0);
    repeat (3) cycle(0, 0, 0, 0, 16'h0);
    cycle(0, 0, 0, 1, 16'hBEEF);
    check_eq("drain_discard", pixelValid, 0);
    idle_until_read(3);
    check_eq("drain_restart_addr", readAddress, BASE);

    // three words in, then push and pop together, then underflow
    for (int i = 0; i < 3; i++) begin
      idle_until_read(3);
      cycle(0, 0, 0, 1, 16'(16'h1000 + i));
    end
    idle_until_read(3);
    cycle(0, 0, 1, 1, 16'h2000);
    repeat (3) cycle(0, 0, 1, 0, 16'h0);
    check_eq("drained_three", pixelValid, 0);
    cycle(0, 0, 1, 0, 16'h0);
    check_eq("underflow_set", underflow, 1);
    repeat (3) cycle(0, 0, 0, 0, 16'h0);
    check_eq("underflow_sticky", underflow, 1);
    cycle(0, 1, 0, 1, 16'h3000);          // frameStart wins over the acknowledge
    check_eq("underflow_clear", underflow, 0);

    // reset during WAIT; a late acknowledge in IDLE is ignored
    idle_until_read(4);
    cycle(1, 0, 0, 0, 16'h0);
    cycle(0, 0, 0, 1, 16'h5555);
    cycle(0, 0, 0, 0, 16'h0);
    check_eq("idle_after_rst", read, 0);
    check_eq("idle_no_word", pixelValid, 0);

    // randomized soak
    cycle(0, 1, 0, 0, 16'h0);
    ack_max = 4;
    rand_run(3000, 45, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
    $fatal(1);
  end

endmodule
